// File: rtl/cvxif_issue_master.sv
// CV-X-IF issue master: forwards core offload requests to a coprocessor, tracks
// outstanding instruction IDs and turns coprocessor results into writebacks or event pulses.
module cvxif_issue_master #(
   parameter int unsigned XLEN            = 64,
   parameter int unsigned ID_W            = 3,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [31:0]     req_instr_i,
   input  logic [XLEN-1:0] req_rs1_i,
   input  logic [XLEN-1:0] req_rs2_i,
   input  logic [ID_W-1:0] req_id_i,
   output logic            x_issue_valid_o,
   input  logic            x_issue_ready_i,
   input  logic            x_issue_accept_i,
   input  logic            x_issue_writeback_i,
   output logic [31:0]     x_issue_instr_o,
   output logic [ID_W-1:0] x_issue_id_o,
   output logic [XLEN-1:0] x_issue_rs0_o,
   output logic [XLEN-1:0] x_issue_rs1_o,
   output logic [1:0]      x_issue_rs_valid_o,
   input  logic            x_result_valid_i,
   output logic            x_result_ready_o,
   input  logic [ID_W-1:0] x_result_id_i,
   input  logic [XLEN-1:0] x_result_data_i,
   input  logic [4:0]      x_result_rd_i,
   input  logic            x_result_we_i,
   input  logic            x_result_exc_i,
   output logic            wb_valid_o,
   output logic [4:0]      wb_rd_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic [ID_W-1:0] wb_id_o,
   output logic            reject_o,
   output logic            exc_o,
   output logic            err_o,
   output logic [ID_W-1:0] evt_id_o
);

   localparam int unsigned NUM_IDS = 2**ID_W;
   localparam int unsigned CNT_W   = ID_W + 1;

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e              state_q, state_d;
   logic [NUM_IDS-1:0]  pending_q, pending_d, set_vec, clr_vec;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                req_hs, issue_hs, issue_acc, issue_rej;
   logic                res_fire, res_hit, res_miss;
   logic                new_valid, new_err;
   logic                hold_valid_q, hold_err_q;
   logic [ID_W-1:0]     hold_id_q;
   logic                unused_writeback;

   // Writeback intent is carried by the result's we flag, so the issue-time hint is ignored.
   assign unused_writeback = x_issue_writeback_i;

   assign req_ready_o        = rst_ni && (state_q == IDLE) &&
                               (count_q < CNT_W'(MAX_OUTSTANDING)) && !pending_q[req_id_i];
   assign x_result_ready_o   = rst_ni;
   assign x_issue_valid_o    = (state_q == ISSUE);
   assign x_issue_rs_valid_o = (state_q == ISSUE) ? 2'b11 : 2'b00;

   assign req_hs    = req_valid_i && req_ready_o;
   assign issue_hs  = (state_q == ISSUE) && x_issue_ready_i;
   assign issue_acc = issue_hs && x_issue_accept_i;
   assign issue_rej = issue_hs && !x_issue_accept_i;
   assign res_fire  = x_result_valid_i && x_result_ready_o;
   // Results are judged against the pre-update pending set, so a same-cycle accept of that ID errs.
   assign res_hit   = res_fire && pending_q[x_result_id_i];
   assign res_miss  = res_fire && !pending_q[x_result_id_i];
   assign new_valid = res_miss || (res_hit && x_result_exc_i);
   assign new_err   = res_miss;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_hs) state_d = ISSUE;
         ISSUE:   if (x_issue_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (issue_acc) set_vec[x_issue_id_o] = 1'b1;
      if (res_hit) clr_vec[x_result_id_i] = 1'b1;
      pending_d = (pending_q | set_vec) & ~clr_vec;
      count_d   = count_q + CNT_W'(issue_acc) - CNT_W'(res_hit);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         pending_q       <= '0;
         count_q         <= '0;
         x_issue_instr_o <= '0;
         x_issue_id_o    <= '0;
         x_issue_rs0_o   <= '0;
         x_issue_rs1_o   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         if (req_hs) begin
            x_issue_instr_o <= req_instr_i;
            x_issue_id_o    <= req_id_i;
            x_issue_rs0_o   <= req_rs1_i;
            x_issue_rs1_o   <= req_rs2_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_valid_o <= 1'b0;
         wb_rd_o    <= '0;
         wb_data_o  <= '0;
         wb_id_o    <= '0;
      end else begin
         wb_valid_o <= res_hit && x_result_we_i && !x_result_exc_i;
         if (res_hit && x_result_we_i && !x_result_exc_i) begin
            wb_rd_o   <= x_result_rd_i;
            wb_data_o <= x_result_data_i;
            wb_id_o   <= x_result_id_i;
         end
      end
   end

   // reject owns evt_id_o when it collides; a displaced exc/err waits one cycle in the hold slot.
   // The slot is one deep: a third event meeting a reject and a full slot is dropped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reject_o     <= 1'b0;
         exc_o        <= 1'b0;
         err_o        <= 1'b0;
         evt_id_o     <= '0;
         hold_valid_q <= 1'b0;
         hold_err_q   <= 1'b0;
         hold_id_q    <= '0;
      end else begin
         reject_o <= 1'b0;
         exc_o    <= 1'b0;
         err_o    <= 1'b0;
         evt_id_o <= '0;
         if (issue_rej) begin
            reject_o <= 1'b1;
            evt_id_o <= x_issue_id_o;
            if (!hold_valid_q) begin
               hold_valid_q <= new_valid;
               hold_err_q   <= new_err;
               hold_id_q    <= x_result_id_i;
            end
         end else if (hold_valid_q) begin
            exc_o        <= !hold_err_q;
            err_o        <= hold_err_q;
            evt_id_o     <= hold_id_q;
            hold_valid_q <= new_valid;
            hold_err_q   <= new_err;
            hold_id_q    <= x_result_id_i;
         end else if (new_valid) begin
            exc_o    <= !new_err;
            err_o    <= new_err;
            evt_id_o <= x_result_id_i;
         end
      end
   end

endmodule
